// File: rtl/dff_pipe.sv
// Enable-gated, synchronously reset delay line for scalars, vectors and matrices.
// Optional simulation checks are compiled in with `define DFF_PIPE_ASSERT_EN.
module dff_pipe #(
   parameter int WIDTH         = 32,
   parameter int ARRAY_SIZE1   = 1,
   parameter int ARRAY_SIZE2   = 1,
   parameter int PIPE_DEPTH    = 1,
   parameter int RETIME_STATUS = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
   output logic [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);

   generate
      if (PIPE_DEPTH == 0) begin : g_wire
         // With no stages the control inputs have nothing to drive.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, reset, en};
         assign out = in;
      end else begin : g_regs
         logic [WIDTH-1:0] stage_q [PIPE_DEPTH][ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];
         logic [WIDTH-1:0] stage_d [PIPE_DEPTH][ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];

         always_comb begin
            // NOTE: default to hold so every path assigns stage_d and no latch is inferred.
            stage_d = stage_q;
            if (reset) begin
               for (int k = 0; k < PIPE_DEPTH; k++) begin
                  for (int i = 0; i < ARRAY_SIZE1; i++) begin
                     for (int j = 0; j < ARRAY_SIZE2; j++) begin
                        stage_d[k][i][j] = '0;
                     end
                  end
               end
            end else if (en) begin
               stage_d[0] = in;
               for (int k = 1; k < PIPE_DEPTH; k++) begin
                  stage_d[k] = stage_q[k-1];
               end
            end
         end

         if (RETIME_STATUS != 0) begin : g_retimed
            // NOTE: non-blocking update so every stage samples the pre-edge value of its predecessor.
            (* retiming_forward = 1, retiming_backward = 1 *)
            always_ff @(posedge clk) begin
               stage_q <= stage_d;
            end
         end else begin : g_plain
            always_ff @(posedge clk) begin
               stage_q <= stage_d;
            end
         end

         assign out = stage_q[PIPE_DEPTH-1];
      end
   endgenerate

`ifdef DFF_PIPE_ASSERT_EN
   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("dff_pipe: WIDTH must be at least 1");
      end
      if (ARRAY_SIZE1 < 1) begin : g_bad_size1
         $error("dff_pipe: ARRAY_SIZE1 must be at least 1");
      end
      if (ARRAY_SIZE2 < 1) begin : g_bad_size2
         $error("dff_pipe: ARRAY_SIZE2 must be at least 1");
      end
      if (PIPE_DEPTH < 0) begin : g_bad_depth
         $error("dff_pipe: PIPE_DEPTH must not be negative");
      end
   endgenerate

   always @(posedge clk) begin
      assert (!$isunknown(reset)) else $error("dff_pipe: reset is X/Z at clock edge");
      assert (!$isunknown(en))    else $error("dff_pipe: en is X/Z at clock edge");
   end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: scalar, matrix, stall, mid-stream reset,
// zero-depth pass-through and retimed-vs-plain equivalence.
module tb_dff_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Scalar, depth 3
   logic       s_rst, s_en;
   logic [0:0] s_in  [0:0][0:0];
   logic [0:0] s_out [0:0][0:0];
   // 3x3 matrix of 24-bit elements, depth 2
   logic        m_rst, m_en;
   logic [23:0] m_in  [2:0][2:0];
   logic [23:0] m_out [2:0][2:0];
   // Byte scalar, depth 3, stall and reset sequences
   logic       p_rst, p_en;
   logic [7:0] p_in  [0:0][0:0];
   logic [7:0] p_out [0:0][0:0];
   // Pass-through, depth 0
   logic        z_rst, z_en;
   logic [31:0] z_in  [0:0][0:0];
   logic [31:0] z_out [0:0][0:0];
   // Plain vs retimed, 2x1 bytes, depth 3
   logic       r_rst, r_en;
   logic [7:0] r_in   [1:0][0:0];
   logic [7:0] r0_out [1:0][0:0];
   logic [7:0] r1_out [1:0][0:0];
   logic [7:0] ret_m  [3][2];

   dff_pipe #(.WIDTH(1), .PIPE_DEPTH(3)) u_scalar (
      .clk(clk), .reset(s_rst), .en(s_en), .in(s_in), .out(s_out));
   dff_pipe #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(2)) u_matrix (
      .clk(clk), .reset(m_rst), .en(m_en), .in(m_in), .out(m_out));
   dff_pipe #(.WIDTH(8), .PIPE_DEPTH(3)) u_stall (
      .clk(clk), .reset(p_rst), .en(p_en), .in(p_in), .out(p_out));
   dff_pipe #(.WIDTH(32), .PIPE_DEPTH(0)) u_zero (
      .clk(clk), .reset(z_rst), .en(z_en), .in(z_in), .out(z_out));
   dff_pipe #(.WIDTH(8), .ARRAY_SIZE1(2), .PIPE_DEPTH(3), .RETIME_STATUS(0)) u_plain (
      .clk(clk), .reset(r_rst), .en(r_en), .in(r_in), .out(r0_out));
   dff_pipe #(.WIDTH(8), .ARRAY_SIZE1(2), .PIPE_DEPTH(3), .RETIME_STATUS(1)) u_retimed (
      .clk(clk), .reset(r_rst), .en(r_en), .in(r_in), .out(r1_out));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] mval(input int c, input int i, input int j);
      logic [23:0] v;
      v = 24'(32'h100 * i + j + c);
      if (c % 2 == 1) v = v + 24'hFFFC00;
      return v;
   endfunction

   // Stall sequence (rows 0-8) followed by mid-stream reset with en low (rows 9-17)
   int p_rst_v [18] = '{0,0,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,0};
   int p_en_v  [18] = '{1,1,0,0,1,1,1,1,1, 1,1,1,0,1,1,1,1,1};
   int p_in_v  [18] = '{1,2,3,3,3,4,0,0,0, 5,6,7,0,8,9,10,0,0};
   int p_exp_v [18] = '{0,0,0,0,1,2,3,4,0, 0,0,5,0,0,0,8,9,10};

   initial begin
      s_rst = 1'b1; s_en = 1'b1; s_in[0][0] = 1'b0;
      m_rst = 1'b1; m_en = 1'b1;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m_in[i][j] = '0;
      p_rst = 1'b1; p_en = 1'b1; p_in[0][0] = '0;
      z_rst = 1'b1; z_en = 1'b0; z_in[0][0] = '0;
      r_rst = 1'b1; r_en = 1'b1; r_in[0][0] = '0; r_in[1][0] = '0;

      tick();
      tick();
      check("s_reset", 32'(s_out[0][0]), 32'h0);
      check("p_reset", 32'(p_out[0][0]), 32'h0);
      s_rst = 1'b0;
      m_rst = 1'b0;
      p_rst = 1'b0;

      // Scalar pulse: visible exactly three edges after capture, for one cycle
      for (int k = 1; k <= 6; k++) begin
         s_in[0][0] = (k == 1) ? 1'b1 : 1'b0;
         tick();
         check($sformatf("s_pulse_%0d", k), 32'(s_out[0][0]), (k == 3) ? 32'h1 : 32'h0);
      end

      // Matrix: after edge c the output holds what was driven before edge c-1
      for (int c = 0; c <= 6; c++) begin
         for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m_in[i][j] = mval(c, i, j);
         tick();
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               check($sformatf("m_c%0d_%0d%0d", c, i, j), 32'(m_out[i][j]),
                     (c == 0) ? 32'h0 : 32'(mval(c - 1, i, j)));
            end
         end
         if (c == 2) check("m_neg", 32'(m_out[2][1]), 32'h00FFFE02);
      end

      // Stall then mid-stream reset
      for (int r = 0; r < 18; r++) begin
         p_rst = p_rst_v[r][0];
         p_en  = p_en_v[r][0];
         p_in[0][0] = 8'(p_in_v[r]);
         tick();
         check($sformatf("p_row%0d", r), 32'(p_out[0][0]), 32'(p_exp_v[r]));
      end

      // Zero depth: pure wire regardless of clock phase and controls
      z_in[0][0] = 32'hDEADBEEF;
      #1;
      check("z_comb", z_out[0][0], 32'hDEADBEEF);
      @(negedge clk); #1;
      check("z_negedge", z_out[0][0], 32'hDEADBEEF);
      z_rst = 1'b0; z_en = 1'b1;
      @(posedge clk); #1;
      check("z_posedge", z_out[0][0], 32'hDEADBEEF);
      z_in[0][0] = 32'h12345678;
      #1;
      check("z_change", z_out[0][0], 32'h12345678);

      // Plain and retimed against the same random stimulus and a reference model
      for (int c = 0; c < 1000; c++) begin
         r_rst = (c == 0) || ($urandom_range(0, 19) == 0);
         r_en  = ($urandom_range(0, 9) < 7);
         r_in[0][0] = 8'($urandom);
         r_in[1][0] = 8'($urandom);
         tick();
         if (r_rst) begin
            for (int k = 0; k < 3; k++) for (int a = 0; a < 2; a++) ret_m[k][a] = '0;
         end else if (r_en) begin
            for (int a = 0; a < 2; a++) begin
               ret_m[2][a] = ret_m[1][a];
               ret_m[1][a] = ret_m[0][a];
               ret_m[0][a] = r_in[a][0];
            end
         end
         for (int a = 0; a < 2; a++) begin
            check($sformatf("r0_c%0d_%0d", c, a), 32'(r0_out[a][0]), 32'(ret_m[2][a]));
            check($sformatf("r1_c%0d_%0d", c, a), 32'(r1_out[a][0]), 32'(ret_m[2][a]));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
